// File: rtl/fpu_pkg.sv
// Shared single-precision constants and field layout for the FPU blocks.
package fpu_pkg;

   localparam int WORD_W = 32;
   localparam int EXP_W  = 8;
   localparam int FRA_W  = 23;
   localparam int BIAS   = 127;
   localparam int LZC_W  = 5;

   localparam int SIGN_BIT = WORD_W - 1;
   localparam int EXP_HI   = WORD_W - 2;
   localparam int EXP_LO   = FRA_W;
   localparam int FRA_HI   = FRA_W - 1;
   localparam int FRA_LO   = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [FRA_W-1:0] fra;
   } sp_t;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-zero counter; an all-zero input yields 31 and callers must not rely on it.
module lzc32
   import fpu_pkg::*;
(
   input  logic [WORD_W-1:0] in_word,
   output logic [LZC_W-1:0]  count
);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      count = '1;
      // Scanning upward lets the highest set bit overwrite any lower one.
      for (int i = 0; i < WORD_W; i++) begin
         if (in_word[i]) count = LZC_W'(WORD_W - 1 - i);
      end
   end

endmodule

// File: rtl/itof.sv
// Signed 32-bit integer to IEEE-754 single converter: 2-stage valid/ready pipeline, RNE rounding.
module itof
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] op,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] result,
   output logic              out_valid,
   input  logic              out_ready
);

   logic              s1_valid_q, s1_valid_d;
   logic              s1_sign_q,  s1_sign_d;
   logic [WORD_W-1:0] s1_mag_q,   s1_mag_d;
   logic [LZC_W-1:0]  s1_lzc_q,   s1_lzc_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] result_q,   result_d;

   logic              s1_load, s2_load;
   logic [WORD_W-1:0] op_mag;
   logic [LZC_W-1:0]  op_lzc;

   logic [WORD_W-1:0] shifted;
   logic [FRA_W-1:0]  mant;
   logic              guard, sticky, round_up;
   logic [FRA_W:0]    mant_rnd;
   logic [EXP_W-1:0]  exp_val;
   sp_t               conv;

   assign s2_load  = ~out_valid_q | out_ready;
   assign s1_load  = ~s1_valid_q | s2_load;
   assign in_ready = s1_load;

   // Two's-complement negate maps -2^31 onto itself, which is the correct unsigned magnitude.
   assign op_mag = op[SIGN_BIT] ? (~op + 32'd1) : op;

   lzc32 u_lzc (
      .in_word (op_mag),
      .count   (op_lzc)
   );

   always_comb begin
      s1_valid_d = s1_load ? in_valid : s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mag_d   = s1_mag_q;
      s1_lzc_d   = s1_lzc_q;
      if (s1_load & in_valid) begin
         s1_sign_d = op[SIGN_BIT];
         s1_mag_d  = op_mag;
         s1_lzc_d  = op_lzc;
      end
   end

   always_comb begin
      shifted  = s1_mag_q << s1_lzc_q;
      mant     = shifted[WORD_W-2:WORD_W-1-FRA_W];
      guard    = shifted[7];
      sticky   = |shifted[6:0];
      round_up = guard & (sticky | mant[0]);
      mant_rnd = {1'b0, mant} + {{FRA_W{1'b0}}, round_up};
      exp_val  = EXP_W'(BIAS + WORD_W - 1) - {{(EXP_W-LZC_W){1'b0}}, s1_lzc_q};
      // A carry out of the mantissa leaves its low bits all zero, so only the exponent moves.
      if (mant_rnd[FRA_W]) exp_val = exp_val + 8'd1;
      conv.sign = s1_sign_q;
      conv.exp  = exp_val;
      conv.fra  = mant_rnd[FRA_W-1:0];
      if (s1_mag_q == '0) conv = '0;
   end

   always_comb begin
      out_valid_d = s2_load ? s1_valid_q : out_valid_q;
      result_d    = (s2_load & s1_valid_q) ? conv : result_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   // NOTE: stage-1 data is qualified by s1_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_lzc_q  <= s1_lzc_d;
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_itof.sv
// Self-checking bench for itof: scoreboard fed by an arithmetic reference model plus directed literals.
module tb_itof;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] op;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic        out_valid;
   logic        out_ready;

   always #5 clk = ~clk;

   itof dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] exp;
      int          acc;
      bit          lat;
   } sb_t;

   sb_t         sb[$];
   bit          lat_mode   = 1'b0;
   bit          mon_en     = 1'b0;
   bit          rand_ready = 1'b0;
   bit          stalled    = 1'b0;
   logic [31:0] held       = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact integer rounding: compare the discarded remainder against half an ulp.
   function automatic logic [31:0] ref_itof(input logic [31:0] v);
      longint unsigned m, q, rem, half;
      int              p, sh, e;
      logic            s;
      s = v[31];
      m = s ? (64'h1_0000_0000 - {32'b0, v}) : {32'b0, v};
      if (m == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      e = p + 127;
      if (p <= 23) begin
         q = m << (23 - p);
      end else begin
         sh   = p - 23;
         q    = m >> sh;
         rem  = m - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
      end
      return {s, e[7:0], q[22:0]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         stalled <= 1'b0;
         sb.delete();
      end else if (mon_en) begin
         sb_t e;
         if (stalled) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_result", result, held);
         end
         check("in_ready", {31'b0, in_ready}, {31'b0, !(sb.size() == 2 && !out_ready)});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_result: got %h expected none", result);
            end else begin
               e = sb.pop_front();
               check("result", result, e.exp);
               if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
            end
         end
         if (in_valid && in_ready) sb.push_back('{ref_itof(op), cyc, lat_mode});
         stalled <= out_valid && !out_ready;
         held    <= result;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [31:0] v);
      int n;
      bit acc;
      n = 0;
      op = v;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         step();
         n++;
      end while (!acc && n < 1000);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1");
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      step();
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (2) step();
   endtask

   logic [31:0] dir_op  [8] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'd16777217, 32'd16777219, 32'd16777221};
   logic [31:0] dir_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4F00_0000,
                                32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};
   logic [31:0] bp_op   [10] = '{32'd3, 32'hFFFF_FFF6, 32'd1000, 32'd12345678, 32'hFF00_0001,
                                 32'd7, 32'd33554435, 32'h4000_0000, 32'hFFFF_FFFE, 32'd255};

   initial begin
      logic [31:0] r;
      reset     = 1'b1;
      in_valid  = 1'b0;
      op        = '0;
      out_ready = 1'b1;
      #1;
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_result", result, 32'h0);
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 8; i++) check("model_pin", ref_itof(dir_op[i]), dir_exp[i]);
      check("model_pin", ref_itof(32'hFFFF_FFFB), 32'hC0A0_0000);

      // Back-to-back corner values, then the rounding ties, with out_ready held high.
      lat_mode = 1'b1;
      for (int i = 0; i < 5; i++) send(dir_op[i]);
      drain();
      for (int i = 5; i < 8; i++) send(dir_op[i]);
      drain();

      lat_mode   = 1'b0;
      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(bp_op[i]);
      drain();

      // Fill both stages, then reset mid-cycle.
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      send(32'd11);
      send(32'd22);
      in_valid = 1'b0;
      step();
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("full_out_valid", {31'b0, out_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_result", result, 32'h0);
      check("async_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      check("hold_in_ready", {31'b0, in_ready}, 32'd1);
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle();
         check("no_stale", {31'b0, out_valid}, 32'd0);
      end
      lat_mode = 1'b1;
      send(32'hFFFF_FFFB);
      drain();

      lat_mode   = 1'b0;
      rand_ready = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         r = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) r = -r;
         send(r);
         if ($urandom_range(0, 7) == 0) idle();
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
